// File: rtl/uart_rx16.sv
// uart_rx16: 8N1 UART receiver with 16x oversampling and 3-sample majority vote.
// All logic runs on clk50. The divider's clk16 is synchronised and edge-detected
// into a one-cycle tick enable.
module uart_rx16 (
   input  logic       clk50,
   input  logic       rst_n,
   input  logic       clk16_i,
   input  logic       rx_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic       frame_err_o,
   output logic       rx_busy_o
);

   localparam int unsigned OVS = 16;
   localparam int unsigned TW  = $clog2(OVS);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BRK
   } state_e;

   // Synchroniser and edge-detect flops
   logic          clk16_meta_q, clk16_s_q, clk16_prev_q;
   logic          rx_meta_q, rx_s_q;
   logic          tick;

   // Receiver state
   state_e        state_q, state_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          samp7_q, samp7_d;
   logic          samp8_q, samp8_d;
   logic          vote;

   // Output registers
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;
   logic          frame_err_q, frame_err_d;

   // Two-flop synchronisers for clk16 and rx, plus clk16 history for edge detect
   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         clk16_meta_q <= 1'b0;
         clk16_s_q    <= 1'b0;
         clk16_prev_q <= 1'b0;
         rx_meta_q    <= 1'b1;
         rx_s_q       <= 1'b1;
      end else begin
         clk16_meta_q <= clk16_i;
         clk16_s_q    <= clk16_meta_q;
         clk16_prev_q <= clk16_s_q;
         rx_meta_q    <= rx_i;
         rx_s_q       <= rx_meta_q;
      end
   end

   assign tick = clk16_s_q & ~clk16_prev_q;

   // Samples at tick_cnt 7 and 8 are stored; the tick-9 sample is the live rx_s
   assign vote = (samp7_q & samp8_q) | (samp7_q & rx_s_q) | (samp8_q & rx_s_q);

   // State, counter, shift register and output registers
   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         tick_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         samp7_q     <= 1'b0;
         samp8_q     <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         samp7_q     <= samp7_d;
         samp8_q     <= samp8_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Next-state logic: everything advances on tick only; pulses self-clear every cycle
   always_comb begin
      state_d     = state_q;
      tick_cnt_d  = tick_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      samp7_d     = samp7_q;
      samp8_d     = samp8_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;

      if (tick) begin
         tick_cnt_d = tick_cnt_q + 1'b1;
         if (tick_cnt_q == TW'(7)) samp7_d = rx_s_q;
         if (tick_cnt_q == TW'(8)) samp8_d = rx_s_q;

         case (state_q)
            IDLE: begin
               tick_cnt_d = '0;
               if (!rx_s_q) begin
                  // The detecting tick is tick 0 of the start bit, so the next tick is 1.
                  state_d    = START;
                  tick_cnt_d = TW'(1);
               end
            end

            START: begin
               if (tick_cnt_q == TW'(9) && vote) begin
                  state_d    = IDLE;
                  tick_cnt_d = '0;
               end else if (tick_cnt_q == TW'(OVS - 1)) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end
            end

            DATA: begin
               if (tick_cnt_q == TW'(9)) begin
                  shreg_d = {vote, shreg_q[7:1]};
               end
               if (tick_cnt_q == TW'(OVS - 1)) begin
                  if (bit_cnt_q == 3'd7) begin
                     state_d = STOP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                  end
               end
            end

            STOP: begin
               if (tick_cnt_q == TW'(9)) begin
                  tick_cnt_d = '0;
                  if (vote) begin
                     rx_data_d  = shreg_q;
                     rx_valid_d = 1'b1;
                     state_d    = IDLE;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = BRK;
                  end
               end
            end

            BRK: begin
               tick_cnt_d = '0;
               if (rx_s_q) begin
                  state_d = IDLE;
               end
            end

            default: begin
               state_d    = IDLE;
               tick_cnt_d = '0;
            end
         endcase
      end
   end

   assign rx_data_o   = rx_data_q;
   assign rx_valid_o  = rx_valid_q;
   assign frame_err_o = frame_err_q;
   assign rx_busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx16.sv
// Directed self-checking bench for uart_rx16.
// clk16 runs with a 32-cycle period so that frames stay short; the DUT only
// counts ticks, so every bit still spans exactly 16 ticks.
`timescale 1ns/1ps
module tb_uart_rx16;

   localparam int  CLK_HALF = 10;       // clk50: 20 ns period
   localparam time T        = 640;      // clk16 period (32 clk50 cycles)
   localparam time BIT      = 16 * T;   // one bit time

   logic       clk50 = 1'b0;
   logic       rst_n = 1'b0;
   logic       clk16 = 1'b0;
   logic       rx    = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       rx_busy;

   int         checks   = 0;
   int         failures = 0;
   int         valid_cnt = 0;
   int         ferr_cnt  = 0;
   logic [7:0] data_log[$];
   time        valid_time = 0;
   time        start_time = 0;

   uart_rx16 dut (
      .clk50       (clk50),
      .rst_n       (rst_n),
      .clk16_i     (clk16),
      .rx_i        (rx),
      .rx_data_o   (rx_data),
      .rx_valid_o  (rx_valid),
      .frame_err_o (frame_err),
      .rx_busy_o   (rx_busy)
   );

   always #(CLK_HALF) clk50 = ~clk50;

   initial begin
      #5;
      forever #(T / 2) clk16 = ~clk16;
   end

   // Count every cycle a pulse is high, so a stretched pulse shows up as an extra count.
   always @(negedge clk50) begin
      if (rx_valid === 1'b1) begin
         valid_cnt++;
         data_log.push_back(rx_data);
         valid_time = $time;
      end
      if (frame_err === 1'b1) ferr_cnt++;
   end

   // Start bits begin just after a clk16 fall, so the detecting tick is half a tick later.
   task automatic align_to_clk16();
      @(negedge clk16);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_val, input bit glitch0);
      start_time = $time;
      rx = 1'b0;
      #(BIT);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         if (glitch0 && i == 0) begin
            #(8 * T);
            rx = 1'b0;
            #(T);
            rx = b[0];
            #(7 * T);
         end else begin
            #(BIT);
         end
      end
      rx = stop_val;
      #(BIT);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rx    = 1'b1;
      #(5 * 2 * CLK_HALF);
      checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
      checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
      @(negedge clk50);
      rst_n = 1'b1;
      #(2 * T);
   endtask

   task automatic test_frame_55();
      int  v0 = valid_cnt;
      int  f0 = ferr_cnt;
      time lat;
      align_to_clk16();
      send_frame(8'h55, 1'b1, 1'b0);
      #(T);
      lat = valid_time - start_time;
      checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL f55_valid_count: got %0d expected 1", valid_cnt - v0); end
      checks++; if (rx_data !== 8'h55) begin failures++; $display("FAIL f55_data: got %h expected 55", rx_data); end
      checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("FAIL f55_ferr_count: got %0d expected 0", ferr_cnt - f0); end
      checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL f55_busy: got %b expected 0", rx_busy); end
      // 153 ticks after the detecting tick, which sits half a tick after the start edge
      checks++;
      if (lat < 153 * T + T / 2 || lat > 154 * T + T / 2) begin
         failures++;
         $display("FAIL f55_latency: got %0t ns expected %0t..%0t ns", lat, 153 * T + T / 2, 154 * T + T / 2);
      end
   endtask

   task automatic test_back_to_back();
      int         v0 = valid_cnt;
      int         f0 = ferr_cnt;
      int         n0 = data_log.size();
      logic [7:0] d0, d1;
      align_to_clk16();
      send_frame(8'hA5, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b0);
      #(T);
      d0 = (data_log.size() > n0)     ? data_log[n0]     : 8'hxx;
      d1 = (data_log.size() > n0 + 1) ? data_log[n0 + 1] : 8'hxx;
      checks++; if (valid_cnt - v0 !== 2) begin failures++; $display("FAIL b2b_valid_count: got %0d expected 2", valid_cnt - v0); end
      checks++; if (d0 !== 8'hA5) begin failures++; $display("FAIL b2b_first_data: got %h expected a5", d0); end
      checks++; if (d1 !== 8'h3C) begin failures++; $display("FAIL b2b_second_data: got %h expected 3c", d1); end
      checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("FAIL b2b_ferr_count: got %0d expected 0", ferr_cnt - f0); end
      checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL b2b_busy: got %b expected 0", rx_busy); end
   endtask

   task automatic test_glitch_short();
      int v0 = valid_cnt;
      int f0 = ferr_cnt;
      align_to_clk16();
      rx = 1'b0;
      #(2 * T);
      checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL short_busy_start: got %b expected 1", rx_busy); end
      #(T);
      rx = 1'b1;
      #(7 * T);
      checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL short_busy_drop: got %b expected 0", rx_busy); end
      #(2 * BIT);
      checks++; if (valid_cnt - v0 !== 0) begin failures++; $display("FAIL short_valid_count: got %0d expected 0", valid_cnt - v0); end
      checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("FAIL short_ferr_count: got %0d expected 0", ferr_cnt - f0); end
   endtask

   task automatic test_frame_err();
      int v0 = valid_cnt;
      int f0 = ferr_cnt;
      align_to_clk16();
      send_frame(8'h0F, 1'b0, 1'b0);
      #(3 * BIT);
      checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL ferr_busy_held_low: got %b expected 1", rx_busy); end
      rx = 1'b1;
      #(2 * T);
      checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL ferr_busy_release: got %b expected 0", rx_busy); end
      #(8 * BIT);
      checks++; if (ferr_cnt - f0 !== 1) begin failures++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - f0); end
      checks++; if (valid_cnt - v0 !== 0) begin failures++; $display("FAIL ferr_valid_count: got %0d expected 0", valid_cnt - v0); end
      checks++; if (rx_data !== 8'h3C) begin failures++; $display("FAIL ferr_data_held: got %h expected 3c", rx_data); end
      v0 = valid_cnt;
      f0 = ferr_cnt;
      align_to_clk16();
      send_frame(8'h81, 1'b1, 1'b0);
      #(T);
      checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL after_ferr_valid_count: got %0d expected 1", valid_cnt - v0); end
      checks++; if (rx_data !== 8'h81) begin failures++; $display("FAIL after_ferr_data: got %h expected 81", rx_data); end
      checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("FAIL after_ferr_ferr_count: got %0d expected 0", ferr_cnt - f0); end
   endtask

   task automatic test_majority();
      int v0 = valid_cnt;
      int f0 = ferr_cnt;
      align_to_clk16();
      send_frame(8'hC3, 1'b1, 1'b1);
      #(T);
      checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL vote_valid_count: got %0d expected 1", valid_cnt - v0); end
      checks++; if (rx_data !== 8'hC3) begin failures++; $display("FAIL vote_data: got %h expected c3", rx_data); end
      checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("FAIL vote_ferr_count: got %0d expected 0", ferr_cnt - f0); end
   endtask

   task automatic test_reset_abort();
      logic [7:0] b = 8'h99;
      int         v0 = valid_cnt;
      int         f0 = ferr_cnt;
      align_to_clk16();
      rx = 1'b0;
      #(BIT);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         #(BIT);
      end
      rx = b[4];
      #(BIT / 2);
      rst_n = 1'b0;
      #(3 * 2 * CLK_HALF);
      checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL abort_reset_data: got %h expected 00", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL abort_reset_valid: got %b expected 0", rx_valid); end
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL abort_reset_ferr: got %b expected 0", frame_err); end
      checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL abort_reset_busy: got %b expected 0", rx_busy); end
      rx = 1'b1;
      #(BIT);
      @(negedge clk50);
      rst_n = 1'b1;
      #(2 * BIT);
      checks++; if (valid_cnt - v0 !== 0) begin failures++; $display("FAIL abort_valid_count: got %0d expected 0", valid_cnt - v0); end
      checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("FAIL abort_ferr_count: got %0d expected 0", ferr_cnt - f0); end
      checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL abort_busy_after: got %b expected 0", rx_busy); end
      align_to_clk16();
      send_frame(8'h7E, 1'b1, 1'b0);
      #(T);
      checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL abort_next_valid_count: got %0d expected 1", valid_cnt - v0); end
      checks++; if (rx_data !== 8'h7E) begin failures++; $display("FAIL abort_next_data: got %h expected 7e", rx_data); end
   endtask

   initial begin
      test_reset();
      test_frame_55();
      test_back_to_back();
      test_glitch_short();
      test_frame_err();
      test_majority();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
